// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake, flush, optional 2-entry skid
// buffer and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 150,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              sk_valid_q,  sk_valid_d;
  logic [DATA_W-1:0] sk_data_q,   sk_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept;

  // With the skid entry, ready comes straight from a flop so out_ready never chains upstream.
  always_comb begin
    if (SKID != 0) begin
      in_ready = !sk_valid_q;
    end else begin
      in_ready = !out_valid_q || out_ready;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    stall_cnt_d = stall_cnt_q;
    accept      = in_valid && in_ready;

    if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (flush) begin
      // Kill held bundles; only the control enables are cleared, payload bits hold.
      out_valid_d                     = 1'b0;
      sk_valid_d                      = 1'b0;
      out_data_d[DATA_W-1 -: CTRL_W]  = '0;
    end else if (SKID != 0) begin
      if (!out_valid_q || out_ready) begin
        // Skid entry is older than anything on in_data, so it always goes first.
        if (sk_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = sk_data_q;
          sk_valid_d  = 1'b0;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        sk_valid_d = 1'b1;
        sk_data_d  = in_data;
      end
    end else begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = out_valid_q && !out_ready;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed table + corner sequences, and random traffic checked
// against a small FIFO model of each instance (skid, no-skid, 4-bit counter).
module tb_pipe_stage_skid;

  localparam int unsigned DW = 150;
  localparam int unsigned CW = 5;
  typedef logic [DW-1:0] bw_t;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    bw_t        d;
    logic       ordy;
    logic       eov;
    bw_t        eod;
    logic       eir;
    logic [15:0] est;
  } vec_t;

  logic CLK = 1'b0;
  logic rst, flush, iv, ordy;
  bw_t  din;

  logic ir_a, ov_a; bw_t od_a; logic [15:0] st_a;
  logic ir_b, ov_b; bw_t od_b; logic [15:0] st_b;
  logic ir_c, ov_c; logic [7:0] od_c; logic [3:0] st_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each stage is a FIFO of capacity 2 (skid) or 1; m_show is what out_data displays.
  int          m_n   [3];
  bw_t         m_e   [3][2];
  bw_t         m_show[3];
  int unsigned m_st  [3];

  vec_t vt[$];

  always #5 CLK = ~CLK;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(rst), .flush(flush), .in_valid(iv), .in_ready(ir_a), .in_data(din),
    .out_valid(ov_a), .out_ready(ordy), .out_data(od_a), .stall_cnt(st_a));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST(rst), .flush(flush), .in_valid(iv), .in_ready(ir_b), .in_data(din),
    .out_valid(ov_b), .out_ready(ordy), .out_data(od_b), .stall_cnt(st_b));

  pipe_stage_skid #(.DATA_W(8), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_c (
    .CLK(CLK), .RST(rst), .flush(flush), .in_valid(iv), .in_ready(ir_c), .in_data(din[7:0]),
    .out_valid(ov_c), .out_ready(ordy), .out_data(od_c), .stall_cnt(st_c));

  task automatic chk(input string nm, input bw_t act, input bw_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bw_t dmask(input int k);
    return (k == 2) ? bw_t'(8'hff) : '1;
  endfunction

  function automatic bw_t cmask(input int k);
    return (k == 2) ? (bw_t'(5'h1f) << 3) : (bw_t'(5'h1f) << (DW - CW));
  endfunction

  function automatic int unsigned smax(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic bit m_ir(input int k);
    return (k == 1) ? (m_n[k] == 0 || ordy) : (m_n[k] < 2);
  endfunction

  task automatic model_step(input int k);
    bit acc;
    acc = iv && m_ir(k);
    if (rst) begin
      m_n[k] = 0; m_show[k] = '0; m_st[k] = 0;
    end else begin
      if (m_n[k] > 0 && !ordy && m_st[k] < smax(k)) m_st[k]++;
      if (flush) begin
        m_n[k] = 0;
        m_show[k] = m_show[k] & ~cmask(k);
      end else begin
        if (m_n[k] > 0 && ordy) begin
          m_e[k][0] = m_e[k][1];
          m_n[k]--;
        end
        if (acc) begin
          m_e[k][m_n[k]] = din & dmask(k);
          m_n[k]++;
        end
        if (m_n[k] > 0) m_show[k] = m_e[k][0];
      end
    end
  endtask

  task automatic mon_dut(input string p, input int k, input bw_t ov, input bw_t od,
                         input bw_t ir, input bw_t st);
    chk($sformatf("%s_out_valid", p), ov, bw_t'(m_n[k] > 0));
    chk($sformatf("%s_out_data", p), od, m_show[k]);
    chk($sformatf("%s_in_ready", p), ir, bw_t'(m_ir(k)));
    chk($sformatf("%s_stall_cnt", p), st, bw_t'(m_st[k]));
  endtask

  // Continuous comparison against the model, then advance the model by the coming edge.
  always @(negedge CLK) begin
    mon_dut("a", 0, bw_t'(ov_a), od_a, bw_t'(ir_a), bw_t'(st_a));
    mon_dut("b", 1, bw_t'(ov_b), od_b, bw_t'(ir_b), bw_t'(st_b));
    mon_dut("c", 2, bw_t'(ov_c), bw_t'(od_c), bw_t'(ir_c), bw_t'(st_c));
    for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic add(input logic r, input logic f, input logic v, input bw_t d, input logic o,
                     input logic eov, input bw_t eod, input logic eir, input logic [15:0] est);
    vec_t x;
    x.rst = r; x.flush = f; x.iv = v; x.d = d; x.ordy = o;
    x.eov = eov; x.eod = eod; x.eir = eir; x.est = est;
    vt.push_back(x);
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input bw_t d, input logic o);
    rst = r; flush = f; iv = v; din = d; ordy = o;
  endtask

  initial begin
    bw_t cb;
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_show[k] = '0; m_st[k] = 0;
    end
    drive(1'b1, 1'b0, 1'b1, bw_t'(9), 1'b1);
    cb = bw_t'(5'h1f) << (DW - CW);

    // Each row: inputs for this cycle, outputs of dut_a expected in this cycle before the edge.
    add(1, 0, 1, bw_t'(9), 1,  0, '0, 1, 0);
    add(1, 0, 1, bw_t'(9), 1,  0, '0, 1, 0);
    add(0, 0, 1, bw_t'(1), 1,  0, '0, 1, 0);
    for (int r = 3; r <= 9; r++) add(0, 0, 1, bw_t'(r - 1), 1, 1, bw_t'(r - 2), 1, 0);
    add(0, 0, 0, '0, 1,        1, bw_t'(8), 1, 0);
    add(0, 0, 0, '0, 1,        0, bw_t'(8), 1, 0);
    add(0, 0, 1, bw_t'(1), 1,  0, bw_t'(8), 1, 0);
    add(0, 0, 1, bw_t'(2), 0,  1, bw_t'(1), 1, 0);
    add(0, 0, 1, bw_t'(3), 0,  1, bw_t'(1), 0, 1);
    add(0, 0, 1, bw_t'(3), 0,  1, bw_t'(1), 0, 2);
    add(0, 0, 1, bw_t'(3), 1,  1, bw_t'(1), 0, 3);
    add(0, 0, 1, bw_t'(3), 1,  1, bw_t'(2), 1, 3);
    add(0, 0, 1, bw_t'(4), 1,  1, bw_t'(3), 1, 3);
    add(0, 0, 0, '0, 1,        1, bw_t'(4), 1, 3);
    add(0, 0, 0, '0, 1,        0, bw_t'(4), 1, 3);
    add(0, 0, 1, cb | 5, 0,    0, bw_t'(4), 1, 3);
    add(0, 0, 1, cb | 6, 0,    1, cb | 5, 1, 3);
    add(0, 1, 1, cb | 7, 0,    1, cb | 5, 0, 4);
    add(0, 0, 0, '0, 1,        0, bw_t'(5), 1, 5);
    add(0, 1, 1, cb | 9, 1,    0, bw_t'(5), 1, 5);
    add(0, 0, 0, '0, 1,        0, bw_t'(5), 1, 5);
    add(0, 0, 0, '0, 1,        0, bw_t'(5), 1, 5);

    @(posedge CLK); #1;
    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].flush, vt[i].iv, vt[i].d, vt[i].ordy);
      @(negedge CLK);
      chk($sformatf("tbl%0d_out_valid", i), bw_t'(ov_a), bw_t'(vt[i].eov));
      chk($sformatf("tbl%0d_out_data", i), od_a, vt[i].eod);
      chk($sformatf("tbl%0d_in_ready", i), bw_t'(ir_a), bw_t'(vt[i].eir));
      chk($sformatf("tbl%0d_stall_cnt", i), bw_t'(st_a), bw_t'(vt[i].est));
      @(posedge CLK); #1;
    end

    // Random traffic with varying back-pressure density.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
            bw_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
            (i < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0));
      @(posedge CLK); #1;
    end

    // No-skid variant: ready must follow out_ready within the same cycle.
    drive(1, 0, 0, '0, 1);
    @(posedge CLK); #1;
    drive(0, 0, 1, bw_t'(8'h21), 0);
    @(posedge CLK); #1;
    drive(0, 0, 1, bw_t'(8'h22), 0);
    #1;
    chk("b_in_ready_stalled", bw_t'(ir_b), bw_t'(0));
    chk("b_held_data", od_b, bw_t'(8'h21));
    ordy = 1'b1;
    #1;
    chk("b_in_ready_release", bw_t'(ir_b), bw_t'(1));
    @(posedge CLK); #1;
    chk("b_new_valid", bw_t'(ov_b), bw_t'(1));
    chk("b_new_data", od_b, bw_t'(8'h22));

    // Counter saturation on the 4-bit instance versus the 16-bit one.
    drive(1, 0, 0, '0, 0);
    @(posedge CLK); #1;
    drive(0, 0, 1, bw_t'(8'h5a), 0);
    @(posedge CLK); #1;
    iv = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("c_stall_saturated", bw_t'(st_c), bw_t'(15));
    chk("c_data_hold", bw_t'(od_c), bw_t'(8'h5a));
    chk("a_stall_unsaturated", bw_t'(st_a), bw_t'(20));
    rst = 1'b1;
    @(posedge CLK); #1;
    chk("c_stall_after_reset", bw_t'(st_c), bw_t'(0));
    chk("a_stall_after_reset", bw_t'(st_a), bw_t'(0));
    rst = 1'b0;
    @(posedge CLK); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
